// File: rtl/sipo_frame_pkg.sv
// Shared state encoding and counter sizing for the serial-to-parallel frame collector.
// PARITY exists only when SIPO_FRAME_PARITY_EN is defined.
package sipo_frame_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_SHIFT  = SHIFT,
`ifdef SIPO_FRAME_PARITY_EN
    S_PARITY = PARITY,
`endif
    S_HOLD   = HOLD
  } state_t;

  // Bits needed to count 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Frame-side bundle: serial strobe/data and start in, parallel word with valid/ready out.
// slave is the collector side, master is the producer/consumer side.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             i_start;
  logic             i_bit_en;
  logic             i_serial;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_busy;
  logic             o_overrun;
  logic             o_parity_err;

  modport slave (
    input  i_start, i_bit_en, i_serial, i_ready,
    output o_data, o_valid, o_busy, o_overrun, o_parity_err
  );

  modport master (
    output i_start, i_bit_en, i_serial, i_ready,
    input  o_data, o_valid, o_busy, o_overrun, o_parity_err
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Left-shifting capture register, MSB first; clear wins over shift; one cycle per bit.
// No backpressure: the controller decides when shifting is allowed.
module sipo_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= {r_q[WIDTH-2:0], i_bit};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Collects WIDTH serial bits into a word held under valid/ready until accepted; valid one edge after the last bit.
// Strobes arriving while held are dropped with o_overrun; SIPO_FRAME_PARITY_EN adds an even-parity bit check.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  sipo_frame_ctrl_if.slave   bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_overrun;
  logic             w_clr;
  logic             w_shift_en;
  logic             w_hs;
  logic [WIDTH-1:0] w_q;

  assign w_hs = (r_state == S_HOLD) && bus.i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_SHIFT;
        end else if (bus.i_bit_en) begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST) begin
`ifdef SIPO_FRAME_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_HOLD;
`endif
          end
        end
      end
`ifdef SIPO_FRAME_PARITY_EN
      S_PARITY: begin
        if (bus.i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_SHIFT;
        end else if (bus.i_bit_en) begin
          w_state_nxt = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        // A start is only honoured together with the handshake that frees the word.
        if (w_hs) begin
          if (bus.i_start) begin
            w_clr       = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter saturates at the last bit; leaving SHIFT happens on that same strobe.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_cnt <= '0;
    end else if (w_shift_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_state == S_HOLD) && bus.i_bit_en;
    end
  end

  sipo_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_shift_en (w_shift_en),
    .i_bit      (bus.i_serial),
    .o_q        (w_q)
  );

`ifdef SIPO_FRAME_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst || w_clr || w_hs) begin
      r_par_err <= 1'b0;
    end else if ((r_state == S_PARITY) && bus.i_bit_en) begin
      r_par_err <= ^{w_q, bus.i_serial};
    end
  end

  assign bus.o_parity_err = r_par_err;
`else
  assign bus.o_parity_err = 1'b0;
`endif

  assign bus.o_data    = w_q;
  assign bus.o_valid   = (r_state == S_HOLD);
`ifdef SIPO_FRAME_PARITY_EN
  assign bus.o_busy    = (r_state == S_SHIFT) || (r_state == S_PARITY);
`else
  assign bus.o_busy    = (r_state == S_SHIFT);
`endif
  assign bus.o_overrun = r_overrun;

endmodule
